// File: rtl/muldiv_hilo_ctrl_if.sv
// Bundles the sequencer's request, write-back and multiply/divide unit signals.
// No latency: wires only.
// No backpressure here; the control unit stalls on busy.
interface muldiv_hilo_ctrl_if;
    logic        start_mult;
    logic        start_div;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_divzero;
    logic [1:0]  md_ctrl;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Environment side: control unit plus the multiply/divide unit.
    modport master (
        output start_mult, start_div, wr_hi, wr_lo, wdata,
        output md_hi, md_lo, md_divzero,
        input  md_ctrl, busy, done, div_zero, hi_q, lo_q
    );

    // Sequencer side.
    modport slave (
        input  start_mult, start_div, wr_hi, wr_lo, wdata,
        input  md_hi, md_lo, md_divzero,
        output md_ctrl, busy, done, div_zero, hi_q, lo_q
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Sequences the iterative mul/div unit and holds the architectural HI/LO pair.
// Latency: start edge E -> HI/LO updated at E+33 (mult) or E+34 (div).
// Backpressure: busy stays high while an op is in flight; starts outside IDLE are dropped.
module muldiv_hilo_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    muldiv_hilo_ctrl_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MULT    = 3'd1,
        S_DIV     = 3'd2,
        S_CAPTURE = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_start;

    assign w_start = bus.start_mult | bus.start_div;

    // State and iteration counter; reset drops md_ctrl at once since it decodes from state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: mult beats div on a simultaneous request; stale divzero ignored on the first div edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.start_mult) begin
                    w_state_nxt = S_MULT;
                end else if (bus.start_div) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MULT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(MULT_CYCLES - 1)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_DIV: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if ((r_cnt != '0) && bus.md_divzero) begin
                    w_state_nxt = S_ABORT;
                end else if (r_cnt == CNT_W'(DIV_CYCLES - 1)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: w_state_nxt = S_IDLE;
            S_ABORT:   w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // HI/LO: MTHI/MTLO only in IDLE when no start is taken; unit result copied on CAPTURE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_start) begin
                        if (bus.wr_hi) r_hi <= bus.wdata;
                        if (bus.wr_lo) r_lo <= bus.wdata;
                    end
                end
                S_CAPTURE: begin
                    r_hi <= bus.md_hi;
                    r_lo <= bus.md_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.md_ctrl  = (r_state == S_MULT) ? 2'd1 :
                          (r_state == S_DIV)  ? 2'd2 : 2'd0;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_CAPTURE);
    assign bus.div_zero = (r_state == S_ABORT);
    assign bus.hi_q     = r_hi;
    assign bus.lo_q     = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for the HI/LO sequencer with hand-computed results.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Unit model is a set of constant Hi/Lo values presented on md_hi/md_lo.
module tb_muldiv_hilo_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   n_mult_edges;
    int   n_div_edges;

    muldiv_hilo_ctrl_if bus ();

    muldiv_hilo_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges seen with each op select value.
    always @(posedge clk) begin
        if (bus.md_ctrl == 2'd1) n_mult_edges <= n_mult_edges + 1;
        if (bus.md_ctrl == 2'd2) n_div_edges  <= n_div_edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.busy && k < 100) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    // Full multiply with exact edge timing; caller is at 1 unit past an IDLE edge.
    task automatic run_mult(input string tag, input logic [31:0] h, input logic [31:0] l,
                            input logic [31:0] old_h, input logic [31:0] old_l);
        int e0;
        bus.md_hi      = h;
        bus.md_lo      = l;
        bus.start_mult = 1'b1;
        tick();
        bus.start_mult = 1'b0;
        e0 = n_mult_edges;
        chk({tag, "_ctrl_E"}, {30'd0, bus.md_ctrl}, 32'd1);
        chk({tag, "_busy_E"}, {31'd0, bus.busy}, 32'd1);
        repeat (31) tick();
        chk({tag, "_ctrl_E31"}, {30'd0, bus.md_ctrl}, 32'd1);
        tick();
        chk({tag, "_done_E32"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_ctrl_E32"}, {30'd0, bus.md_ctrl}, 32'd0);
        chk({tag, "_hi_hold_E32"}, bus.hi_q, old_h);
        chk({tag, "_lo_hold_E32"}, bus.lo_q, old_l);
        tick();
        chk({tag, "_hi_E33"}, bus.hi_q, h);
        chk({tag, "_lo_E33"}, bus.lo_q, l);
        chk({tag, "_done_E33"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_busy_E33"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_edges"}, n_mult_edges - e0, 32'd32);
    endtask

    initial begin
        int e0;
        n_chk = 0;
        n_pass = 0;
        n_mult_edges = 0;
        n_div_edges = 0;
        reset = 1'b0;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.wr_hi      = 1'b0;
        bus.wr_lo      = 1'b0;
        bus.wdata      = '0;
        bus.md_hi      = '0;
        bus.md_lo      = '0;
        bus.md_divzero = 1'b0;

        // Reset state
        #1;
        chk("rst_ctrl", {30'd0, bus.md_ctrl}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dz",   {31'd0, bus.div_zero}, 32'd0);
        chk("rst_hi",   bus.hi_q, 32'd0);
        chk("rst_lo",   bus.lo_q, 32'd0);
        #22;
        reset = 1'b1;
        tick();

        // 7 * -3 = -21
        run_mult("m1", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd0, 32'd0);

        // -17 / 5: quotient -3, remainder -2
        bus.md_hi     = 32'hFFFF_FFFE;
        bus.md_lo     = 32'hFFFF_FFFD;
        bus.start_div = 1'b1;
        tick();
        bus.start_div = 1'b0;
        e0 = n_div_edges;
        chk("d1_ctrl_E", {30'd0, bus.md_ctrl}, 32'd2);
        repeat (32) tick();
        chk("d1_ctrl_E32", {30'd0, bus.md_ctrl}, 32'd2);
        chk("d1_hi_hold_E32", bus.hi_q, 32'hFFFF_FFFF);
        tick();
        chk("d1_done_E33", {31'd0, bus.done}, 32'd1);
        chk("d1_ctrl_E33", {30'd0, bus.md_ctrl}, 32'd0);
        tick();
        chk("d1_hi_E34", bus.hi_q, 32'hFFFF_FFFE);
        chk("d1_lo_E34", bus.lo_q, 32'hFFFF_FFFD);
        chk("d1_busy_E34", {31'd0, bus.busy}, 32'd0);
        chk("d1_edges", n_div_edges - e0, 32'd33);

        // Divide by zero: stale flag at the first edge must be ignored, abort after E+2
        bus.md_hi      = 32'hDEAD_0001;
        bus.md_lo      = 32'hDEAD_0002;
        bus.md_divzero = 1'b1;
        bus.start_div  = 1'b1;
        tick();
        bus.start_div = 1'b0;
        chk("dz_ctrl_E", {30'd0, bus.md_ctrl}, 32'd2);
        tick();
        chk("dz_ctrl_E1", {30'd0, bus.md_ctrl}, 32'd2);
        chk("dz_flag_E1", {31'd0, bus.div_zero}, 32'd0);
        tick();
        chk("dz_flag_E2", {31'd0, bus.div_zero}, 32'd1);
        chk("dz_ctrl_E2", {30'd0, bus.md_ctrl}, 32'd0);
        chk("dz_busy_E2", {31'd0, bus.busy}, 32'd1);
        chk("dz_done_E2", {31'd0, bus.done}, 32'd0);
        bus.md_divzero = 1'b0;
        tick();
        chk("dz_flag_E3", {31'd0, bus.div_zero}, 32'd0);
        chk("dz_busy_E3", {31'd0, bus.busy}, 32'd0);
        chk("dz_done_E3", {31'd0, bus.done}, 32'd0);
        chk("dz_hi_keep", bus.hi_q, 32'hFFFF_FFFE);
        chk("dz_lo_keep", bus.lo_q, 32'hFFFF_FFFD);

        // Both starts together: mult wins; mid-op div start and MTHI ignored
        bus.md_hi      = 32'h1111_1111;
        bus.md_lo      = 32'h2222_2222;
        bus.start_mult = 1'b1;
        bus.start_div  = 1'b1;
        tick();
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        chk("both_ctrl", {30'd0, bus.md_ctrl}, 32'd1);
        repeat (5) tick();
        bus.start_div = 1'b1;
        bus.wr_hi     = 1'b1;
        bus.wdata     = 32'h1234_5678;
        tick();
        bus.start_div = 1'b0;
        bus.wr_hi     = 1'b0;
        chk("mid_ctrl", {30'd0, bus.md_ctrl}, 32'd1);
        chk("mid_hi", bus.hi_q, 32'hFFFF_FFFE);
        wait_idle("both_timeout");
        chk("both_hi", bus.hi_q, 32'h1111_1111);
        chk("both_lo", bus.lo_q, 32'h2222_2222);

        // MTHI/MTLO in IDLE, then start colliding with MTLO
        bus.wr_hi = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        tick();
        bus.wr_hi = 1'b0;
        chk("mthi", bus.hi_q, 32'hA5A5_A5A5);
        chk("mthi_lo_keep", bus.lo_q, 32'h2222_2222);
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h5A5A_5A5A;
        tick();
        bus.wr_lo = 1'b0;
        chk("mtlo", bus.lo_q, 32'h5A5A_5A5A);
        bus.md_hi      = 32'h0BAD_F00D;
        bus.md_lo      = 32'h600D_CAFE;
        bus.start_mult = 1'b1;
        bus.wr_lo      = 1'b1;
        bus.wdata      = 32'hDEAD_BEEF;
        tick();
        bus.start_mult = 1'b0;
        bus.wr_lo      = 1'b0;
        chk("coll_ctrl", {30'd0, bus.md_ctrl}, 32'd1);
        chk("coll_lo", bus.lo_q, 32'h5A5A_5A5A);
        wait_idle("coll_timeout");
        chk("coll_hi_res", bus.hi_q, 32'h0BAD_F00D);

        // Async reset mid-multiply at counter 15
        bus.start_mult = 1'b1;
        tick();
        bus.start_mult = 1'b0;
        repeat (15) tick();
        chk("ar_ctrl_pre", {30'd0, bus.md_ctrl}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ctrl", {30'd0, bus.md_ctrl}, 32'd0);
        chk("ar_busy", {31'd0, bus.busy}, 32'd0);
        chk("ar_hi", bus.hi_q, 32'd0);
        chk("ar_lo", bus.lo_q, 32'd0);
        #2;
        reset = 1'b1;
        tick();
        run_mult("m2", 32'h0000_0001, 32'h8000_0000, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
